sonar_scheduler: RTL and testbench

SONAR_SCHEDULER -- requirements
Module: sonar_scheduler

---
 rtl/rover_pkg.sv | 20 ++
 rtl/echo_sync.sv | 23 ++
 rtl/sonar_scheduler.sv | 136 +++++++++++++
 tb/tb_sonar_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rover_pkg.sv
// Shared rover definitions: sonar scheduler state encoding and default timing
// constants for a 100 MHz system clock.
package rover_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } sonar_state_t;

  localparam int DEF_N_SENSORS         = 2;
  localparam int DEF_TRIG_CLKS         = 1000;     // 10 us trigger pulse
  localparam int DEF_CRASH_CLKS        = 294117;   // echo widths up to this flag a crash
  localparam int DEF_RISE_TIMEOUT_CLKS = 100000;   // 1 ms wait for echo rise
  localparam int DEF_MAX_ECHO_CLKS     = 3800000;  // 38 ms no-object echo
  localparam int DEF_HOLDOFF_CLKS      = 6000000;  // 60 ms gap between pings

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for a bundle of independent asynchronous lines.
module echo_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_p0 <= '0;
      q       <= '0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin ultrasonic ranger scheduler: triggers one sensor at a time,
// times its echo, publishes the width and maintains a per-sensor crash flag.
module sonar_scheduler
  import rover_pkg::*;
#(
  parameter int N_SENSORS         = DEF_N_SENSORS,
  parameter int TRIG_CLKS         = DEF_TRIG_CLKS,
  parameter int CRASH_CLKS        = DEF_CRASH_CLKS,
  parameter int RISE_TIMEOUT_CLKS = DEF_RISE_TIMEOUT_CLKS,
  parameter int MAX_ECHO_CLKS     = DEF_MAX_ECHO_CLKS,
  parameter int HOLDOFF_CLKS      = DEF_HOLDOFF_CLKS,
  localparam int SEL_W = $clog2(N_SENSORS > 1 ? N_SENSORS : 2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [N_SENSORS-1:0] echo,
  output logic [N_SENSORS-1:0] trigger,
  output logic [N_SENSORS-1:0] is_crash,
  output logic                 meas_valid,
  output logic [SEL_W-1:0]     meas_sensor,
  output logic [31:0]          meas_width,
  output logic                 meas_timeout
);

  sonar_state_t         state;
  logic [SEL_W-1:0]     cur;
  logic [31:0]          timer;
  logic [N_SENSORS-1:0] echo_s;
  logic                 echo_cur;
  logic [SEL_W-1:0]     next_cur;
  logic [31:0]          fin_width;

  function automatic logic [N_SENSORS-1:0] one_hot(input logic [SEL_W-1:0] idx);
    logic [N_SENSORS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic crash_of(input logic [31:0] w);
    return (w != 32'd0) && (w <= 32'(CRASH_CLKS));
  endfunction

  echo_sync #(.WIDTH(N_SENSORS)) u_echo_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (echo),
    .q     (echo_s)
  );

  assign echo_cur  = echo_s[cur];
  assign next_cur  = (cur == SEL_W'(N_SENSORS - 1)) ? '0 : cur + 1'b1;
  // Still-high echo at the limit means saturation; otherwise the count so far.
  assign fin_width = echo_cur ? 32'(MAX_ECHO_CLKS) : timer;

  // One timer serves as trigger counter, rise timeout, echo width and holdoff.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cur          <= '0;
      timer        <= '0;
      trigger      <= '0;
      is_crash     <= '0;
      meas_valid   <= 1'b0;
      meas_sensor  <= '0;
      meas_width   <= '0;
      meas_timeout <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state   <= TRIG;
            trigger <= one_hot(cur);
            timer   <= '0;
          end
        end
        TRIG: begin
          if (timer == 32'(TRIG_CLKS - 1)) begin
            state   <= WAIT_RISE;
            trigger <= '0;
            timer   <= '0;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        WAIT_RISE: begin
          if (echo_cur) begin
            // The cycle that shows the rise is the first counted echo clock.
            state <= MEASURE;
            timer <= 32'd1;
          end else if (timer == 32'(RISE_TIMEOUT_CLKS - 1)) begin
            state        <= HOLDOFF;
            timer        <= '0;
            meas_valid   <= 1'b1;
            meas_sensor  <= cur;
            meas_width   <= '0;
            meas_timeout <= 1'b1;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        MEASURE: begin
          if (!echo_cur || timer >= 32'(MAX_ECHO_CLKS - 1)) begin
            state         <= HOLDOFF;
            timer         <= '0;
            meas_valid    <= 1'b1;
            meas_sensor   <= cur;
            meas_width    <= fin_width;
            meas_timeout  <= 1'b0;
            is_crash[cur] <= crash_of(fin_width);
          end else begin
            timer <= timer + 32'd1;
          end
        end
        HOLDOFF: begin
          if (timer == 32'(HOLDOFF_CLKS - 1)) begin
            cur   <= next_cur;
            timer <= '0;
            if (enable) begin
              state   <= TRIG;
              trigger <= one_hot(next_cur);
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_scheduler.sv
// Self-checking bench for sonar_scheduler with short timing parameters and a
// transaction-level model of expected widths and crash flags.
module tb_sonar_scheduler;

  localparam int N     = 2;
  localparam int TRIG  = 10;
  localparam int CRASH = 50;
  localparam int RISE  = 40;
  localparam int MAXW  = 200;
  localparam int HOLD  = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [N-1:0]  echo;
  logic [N-1:0]  trigger;
  logic [N-1:0]  is_crash;
  logic          meas_valid;
  logic [0:0]    meas_sensor;
  logic [31:0]   meas_width;
  logic          meas_timeout;

  int            checks = 0;
  int            errors = 0;
  int            exp_cur = 0;
  logic [N-1:0]  crash_m = '0;

  always #5 clk = ~clk;

  sonar_scheduler #(
    .N_SENSORS(N), .TRIG_CLKS(TRIG), .CRASH_CLKS(CRASH),
    .RISE_TIMEOUT_CLKS(RISE), .MAX_ECHO_CLKS(MAXW), .HOLDOFF_CLKS(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .echo(echo),
    .trigger(trigger), .is_crash(is_crash), .meas_valid(meas_valid),
    .meas_sensor(meas_sensor), .meas_width(meas_width), .meas_timeout(meas_timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full ping on sensor exp_cur: echo of 'width' clocks starting 'dly'
  // clocks after trigger falls (width 0 = no echo). Noise on the other line.
  task automatic run_meas(input int width, input int dly, input bit drop_en, input string name);
    int s, hi, t, n, t_valid, vcnt, exp_w, got_w, got_s, got_to;
    bit multi, seen;
    logic [N-1:0] echo_v, exp_trig;
    s = exp_cur;
    exp_trig = '0;
    exp_trig[s] = 1'b1;
    multi = 1'b0; seen = 1'b0; vcnt = 0; t_valid = -1;
    got_w = -1; got_s = -1; got_to = -1;
    n = 0;
    while (trigger == '0 && n < 200) begin step(); n++; end
    checks++;
    if (trigger !== exp_trig) begin
      $display("FAIL %s trig_select got %b want %b", name, trigger, exp_trig); errors++;
    end
    hi = 0;
    while (trigger != '0 && hi < 100) begin
      if ($countones(trigger) > 1) multi = 1'b1;
      hi++; step();
    end
    checks++;
    if (hi != TRIG) begin
      $display("FAIL %s trig_width got %0d want %0d", name, hi, TRIG); errors++;
    end
    t = 0;
    while (t < 700) begin
      if ($countones(trigger) > 1) multi = 1'b1;
      if (meas_valid === 1'b1) begin
        vcnt++;
        if (!seen) begin
          seen = 1'b1; t_valid = t;
          got_w = int'(meas_width); got_s = int'(meas_sensor); got_to = int'(meas_timeout);
        end
      end
      if (seen && t >= dly + width + 2 && t >= t_valid + 1) break;
      echo_v = '0;
      if (t >= dly && t < dly + width) echo_v[s] = 1'b1;
      if (!seen) echo_v[1-s] = 1'($urandom_range(0, 1));
      echo = echo_v;
      if (drop_en && t == dly + 3) enable = 1'b0;
      step(); t++;
    end
    echo = '0;
    exp_w = (width > MAXW) ? MAXW : width;
    if (width != 0) crash_m[s] = (exp_w >= 1 && exp_w <= CRASH);
    checks++;
    if (vcnt != 1) begin
      $display("FAIL %s valid_pulses got %0d want 1", name, vcnt); errors++;
    end
    checks++;
    if (got_s != s) begin
      $display("FAIL %s meas_sensor got %0d want %0d", name, got_s, s); errors++;
    end
    checks++;
    if (got_to != (width == 0 ? 1 : 0)) begin
      $display("FAIL %s meas_timeout got %0d want %0d", name, got_to, (width == 0)); errors++;
    end
    checks++;
    if (got_w != exp_w) begin
      $display("FAIL %s meas_width got %0d want %0d", name, got_w, exp_w); errors++;
    end
    checks++;
    if (meas_width !== 32'(exp_w)) begin
      $display("FAIL %s width_hold got %0d want %0d", name, meas_width, exp_w); errors++;
    end
    checks++;
    if (is_crash !== crash_m) begin
      $display("FAIL %s is_crash got %b want %b", name, is_crash, crash_m); errors++;
    end
    checks++;
    if (multi) begin
      $display("FAIL %s trig_onehot got multi want onehot", name); errors++;
    end
    if (width == 0) begin
      checks++;
      if (t_valid < RISE - 2 || t_valid > RISE + 5) begin
        $display("FAIL %s timeout_delay got %0d want %0d..%0d", name, t_valid, RISE - 2, RISE + 5);
        errors++;
      end
    end
    exp_cur = (s + 1) % N;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; echo = '0;
    repeat (3) step();
    checks++;
    if (trigger !== '0 || is_crash !== '0) begin
      $display("FAIL reset trig_crash got %b/%b want 00/00", trigger, is_crash); errors++;
    end
    checks++;
    if (meas_valid !== 1'b0 || meas_timeout !== 1'b0 || meas_sensor !== 1'b0) begin
      $display("FAIL reset meas_flags got %b%b%b want 000", meas_valid, meas_timeout, meas_sensor);
      errors++;
    end
    checks++;
    if (meas_width !== 32'd0) begin
      $display("FAIL reset meas_width got %0d want 0", meas_width); errors++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    enable = 1'b1;
    run_meas(30, 5, 1'b0, "basic_s0");
  endtask

  task automatic test_crash_boundary();
    run_meas(50, 7, 1'b0, "crash50_s1");
    run_meas(12, 2, 1'b0, "fill_s0");
    run_meas(51, 0, 1'b0, "crash51_s1");
  endtask

  task automatic test_timeout();
    run_meas(0, 0, 1'b0, "timeout_s0");
  endtask

  task automatic test_saturate();
    run_meas(215, 4, 1'b0, "saturate_s1");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      run_meas(int'($urandom_range(1, 215)), int'($urandom_range(0, 30)), 1'b0, "random");
  endtask

  task automatic test_enable_drop();
    int trig_seen;
    run_meas(40, 3, 1'b1, "endrop");
    trig_seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (trigger != '0) trig_seen++;
      step();
    end
    checks++;
    if (trig_seen != 0) begin
      $display("FAIL endrop parked got %0d trigger cycles want 0", trig_seen); errors++;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit vseen;
    enable = 1'b1;
    run_meas(20, 5, 1'b0, "pre_reset");
    n = 0;
    while (trigger == '0 && n < 200) begin step(); n++; end
    step(); step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    exp_cur = 0; crash_m = '0;
    checks++;
    if (trigger !== '0 || is_crash !== '0) begin
      $display("FAIL rst_trig trig_crash got %b/%b want 00/00", trigger, is_crash); errors++;
    end
    n = 0;
    while (trigger == '0 && n < 50) begin step(); n++; end
    checks++;
    if (trigger !== 2'b01) begin
      $display("FAIL rst_trig restart got %b want 01", trigger); errors++;
    end
    n = 0;
    while (trigger != '0 && n < 50) begin step(); n++; end
    echo = 2'b01;
    repeat (12) step();
    rst_n = 1'b0; step(); rst_n = 1'b1; echo = '0;
    checks++;
    if (trigger !== '0 || is_crash !== '0 || meas_valid !== 1'b0 || meas_width !== 32'd0) begin
      $display("FAIL rst_meas outputs got %b/%b/%b/%0d want 00/00/0/0",
               trigger, is_crash, meas_valid, meas_width);
      errors++;
    end
    vseen = 1'b0; n = 0;
    while (trigger == '0 && n < 50) begin
      if (meas_valid === 1'b1) vseen = 1'b1;
      step(); n++;
    end
    checks++;
    if (vseen) begin
      $display("FAIL rst_meas stray_valid got 1 want 0"); errors++;
    end
    checks++;
    if (trigger !== 2'b01) begin
      $display("FAIL rst_meas restart got %b want 01", trigger); errors++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_crash_boundary();
    test_timeout();
    test_saturate();
    test_random();
    test_enable_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
